// File: rtl/count_gate_ctrl.sv
// count_gate_ctrl
//   Sequencer for a bank of rising-edge pulse counters. It opens a fixed-length
//   counting gate, snapshots every channel in one cycle, clears the bank, and
//   then streams the snapshot out one channel at a time over a valid/ready port.
//   Frames are one-shot or re-arm automatically when cont_mode is set.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        asynchronous reset, active-high
//   start      one-cycle frame request, honoured only when idle
//   stop       abort, returns to idle on the next edge from any state
//   cont_mode  re-arm after each frame (sampled at frame end)
//   cnt_bus    counter outputs, channel k = cnt_bus[k*CW +: CW]
//   en_count   gate to the counter bank (counters clear while low)
//   busy       high whenever a frame is in progress
//   out_valid  out_ch/out_data/out_last hold a valid word
//   out_ready  downstream accepts the word when out_valid is high
//   out_ch     channel index of the current word
//   out_data   snapshot count of channel out_ch
//   out_last   marks the word for channel NCH-1
//   sat_flag   some snapshot word was all-ones (held until the next arm)
//   frame_done one-cycle pulse after the last word is accepted

module count_gate_ctrl #(
    parameter int NCH         = 16,
    parameter int CW          = 16,
    parameter int GATE_CYCLES = 50000000,
    parameter int GW          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              cont_mode,
    input  logic [NCH*CW-1:0] cnt_bus,
    output logic              en_count,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_ch,
    output logic [CW-1:0]     out_data,
    output logic              out_last,
    output logic              sat_flag,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_SNAP,
        S_SEND,
        S_DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [GW-1:0] gate_cnt;
    logic [CW-1:0] snap [NCH];
    logic          xfer;
    logic          gate_end;
    logic          any_sat;
    logic [3:0]    next_ch;

    // out_valid is only ever high in SEND, so a transfer implies SEND.
    assign xfer     = out_valid && out_ready;
    assign gate_end = (gate_cnt == GW'(GATE_CYCLES - 1));
    assign next_ch  = out_ch + 4'd1;

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        next_state = state;
        if (stop) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) next_state = S_ARM;
                S_ARM:   next_state = S_GATE;
                S_GATE:  if (gate_end) next_state = S_SNAP;
                S_SNAP:  next_state = S_SEND;
                S_SEND:  if (xfer && out_last) next_state = S_DONE;
                S_DONE:  next_state = cont_mode ? S_ARM : S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Saturation detect on the live bus; only latched on the snapshot edge.
    always_comb begin
        any_sat = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (cnt_bus[k*CW +: CW] == {CW{1'b1}}) begin
                any_sat = 1'b1;
            end
        end
    end

    // State register. The control outputs are decoded from next_state so
    // they are registered yet line up exactly with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            en_count   <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= next_state;
            en_count   <= (next_state == S_GATE);
            busy       <= (next_state != S_IDLE);
            out_valid  <= (next_state == S_SEND);
            frame_done <= (next_state == S_DONE);
        end
    end

    // Gate length counter: zeroed in ARM, runs 0..GATE_CYCLES-1 during GATE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
        end else if (state == S_ARM) begin
            gate_cnt <= '0;
        end else if (state == S_GATE && !gate_end) begin
            gate_cnt <= gate_cnt + GW'(1);
        end
    end

    // Snapshot capture and readout datapath. Channel 0 is loaded straight
    // from the bus so the first word is ready in the first SEND cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                snap[k] <= '0;
            end
            out_ch   <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (next_state == S_ARM) begin
                sat_flag <= 1'b0;
            end
            if (state == S_SNAP && !stop) begin
                for (int k = 0; k < NCH; k++) begin
                    snap[k] <= cnt_bus[k*CW +: CW];
                end
                sat_flag <= any_sat;
                out_ch   <= '0;
                out_data <= cnt_bus[CW-1:0];
                out_last <= (NCH == 1);
            end else if (xfer && !out_last) begin
                out_ch   <= next_ch;
                out_data <= snap[next_ch];
                out_last <= (next_ch == 4'(NCH - 1));
            end
        end
    end

endmodule

// File: tb/tb_count_gate_ctrl.sv
module tb_count_gate_ctrl;

    localparam int NCH = 16;
    localparam int CW  = 16;
    localparam int GC  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              cont_mode;
    logic              out_ready;
    logic [NCH*CW-1:0] cnt_bus;
    logic              en_count;
    logic              busy;
    logic              out_valid;
    logic [3:0]        out_ch;
    logic [CW-1:0]     out_data;
    logic              out_last;
    logic              sat_flag;
    logic              frame_done;

    int vectors     = 0;
    int miscompares = 0;

    // Expected snapshot contents for the frame in flight.
    logic [CW-1:0] pat [NCH];

    count_gate_ctrl #(
        .NCH(NCH), .CW(CW), .GATE_CYCLES(GC), .GW(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont_mode(cont_mode),
        .cnt_bus(cnt_bus), .en_count(en_count), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
        .out_last(out_last), .sat_flag(sat_flag), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH*CW-1:0] packPattern();
        logic [NCH*CW-1:0] b;
        for (int k = 0; k < NCH; k++) b[k*CW +: CW] = pat[k];
        return b;
    endfunction

    function automatic logic [NCH*CW-1:0] randomBus();
        logic [NCH*CW-1:0] b;
        for (int k = 0; k < NCH; k++) b[k*CW +: CW] = CW'($urandom);
        return b;
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_en"},    32'(en_count),   32'd0);
        checkOutput({tag, "_busy"},  32'(busy),       32'd0);
        checkOutput({tag, "_valid"}, 32'(out_valid),  32'd0);
        checkOutput({tag, "_done"},  32'(frame_done), 32'd0);
    endtask

    // Runs one frame and returns while observing its DONE cycle.
    // readyMode: 0 = always ready, 1 = toggle 1/0, 2 = random.
    // abortCh >= 0 asserts rst while that channel is being presented.
    task automatic applyStimulus(input int readyMode, input bit fromDone,
                                 input bit contNext, input int abortCh);
        bit expSat;
        int ch;
        int cyc;
        bit r;
        expSat = 1'b0;
        for (int k = 0; k < NCH; k++) if (pat[k] == 16'hFFFF) expSat = 1'b1;

        if (!fromDone) start = 1'b1;
        tick();
        start     = 1'b0;
        cont_mode = contNext;
        checkOutput("arm_en",   32'(en_count),  32'd0);
        checkOutput("arm_busy", 32'(busy),      32'd1);
        checkOutput("arm_sat",  32'(sat_flag),  32'd0);
        checkOutput("arm_done", 32'(frame_done), 32'd0);

        for (int i = 0; i < GC; i++) begin
            cnt_bus = randomBus();
            tick();
            checkOutput($sformatf("gate%0d_en", i), 32'(en_count), 32'd1);
        end

        tick();
        checkOutput("snap_en",    32'(en_count),  32'd0);
        checkOutput("snap_valid", 32'(out_valid), 32'd0);
        cnt_bus = packPattern();

        tick();
        ch  = 0;
        cyc = 0;
        while (ch < NCH && cyc < 200) begin
            cnt_bus = randomBus();
            checkOutput($sformatf("send_valid_c%0d", ch), 32'(out_valid), 32'd1);
            checkOutput($sformatf("send_ch_c%0d", ch),    32'(out_ch),    32'(ch));
            checkOutput($sformatf("send_data_c%0d", ch),  32'(out_data),  32'(pat[ch]));
            checkOutput($sformatf("send_last_c%0d", ch),  32'(out_last),  32'(ch == NCH - 1));
            checkOutput($sformatf("send_sat_c%0d", ch),   32'(sat_flag),  32'(expSat));
            checkOutput($sformatf("send_en_c%0d", ch),    32'(en_count),  32'd0);
            if (ch == abortCh) begin
                rst = 1'b1;
                #1;
                checkOutput("rst_valid", 32'(out_valid), 32'd0);
                checkOutput("rst_busy",  32'(busy),      32'd0);
                checkOutput("rst_data",  32'(out_data),  32'd0);
                checkOutput("rst_ch",    32'(out_ch),    32'd0);
                tick();
                rst = 1'b0;
                tick();
                checkIdle("post_rst");
                return;
            end
            case (readyMode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = (cyc > 100) ? 1'b1 : 1'($urandom % 2);
            endcase
            out_ready = r;
            tick();
            if (r) ch++;
            cyc++;
        end
        out_ready = 1'b0;
        checkOutput("words_sent", 32'(ch), 32'(NCH));
        if (readyMode == 0) checkOutput("send_cycles", 32'(cyc), 32'(NCH));
        checkOutput("done_valid", 32'(out_valid),  32'd0);
        checkOutput("done_pulse", 32'(frame_done), 32'd1);
        checkOutput("done_busy",  32'(busy),       32'd1);
        checkOutput("done_sat",   32'(sat_flag),   32'(expSat));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cont_mode = 1'b0;
        out_ready = 1'b0;
        cnt_bus   = '0;
        #1;
        checkIdle("reset");
        checkOutput("reset_ch",   32'(out_ch),   32'd0);
        checkOutput("reset_data", 32'(out_data), 32'd0);
        checkOutput("reset_last", 32'(out_last), 32'd0);
        checkOutput("reset_sat",  32'(sat_flag), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Idle with no start: nothing moves.
        for (int i = 0; i < 6; i++) begin
            cnt_bus = randomBus();
            tick();
            checkIdle("idle");
        end

        // Single frame, channel k = k*3, always ready.
        for (int k = 0; k < NCH; k++) pat[k] = CW'(k * 3);
        applyStimulus(0, 1'b0, 1'b0, -1);
        tick();
        checkIdle("after_single");

        // Backpressure with out_ready toggling.
        for (int k = 0; k < NCH; k++) pat[k] = CW'($urandom);
        applyStimulus(1, 1'b0, 1'b0, -1);
        tick();
        checkIdle("after_bp");

        // Saturation on channel 7, then continuous re-arm into a clean frame.
        for (int k = 0; k < NCH; k++) pat[k] = CW'($urandom_range(0, 16'hFFFE));
        pat[7] = 16'hFFFF;
        applyStimulus(2, 1'b0, 1'b1, -1);
        for (int k = 0; k < NCH; k++) pat[k] = CW'($urandom_range(0, 16'hFFFE));
        applyStimulus(0, 1'b1, 1'b0, -1);
        tick();
        checkIdle("after_cont");

        // Randomized frames with occasional saturated words.
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NCH; k++)
                pat[k] = ($urandom % 10 == 0) ? 16'hFFFF : CW'($urandom);
            applyStimulus(2, 1'b0, 1'b0, -1);
            tick();
            checkIdle("after_rand");
        end

        // Stop in the middle of the gate.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("pre_stop_en", 32'(en_count), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkIdle("stop");
        for (int i = 0; i < GC + 4; i++) begin
            tick();
            checkIdle("post_stop");
        end

        // Reset while channel 5 is being presented, then a full fresh frame.
        for (int k = 0; k < NCH; k++) pat[k] = CW'($urandom);
        applyStimulus(0, 1'b0, 1'b0, 5);
        for (int k = 0; k < NCH; k++) pat[k] = CW'($urandom);
        applyStimulus(0, 1'b0, 1'b0, -1);
        tick();
        checkIdle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
